// File: rtl/onehot_to_therm.sv
// One-hot to thermometer converter with parallel-prefix OR network.
// Combinational therm/none/multi plus enable-gated registered copies.
module onehot_to_therm #(
  parameter int N   = 32,
  parameter int DIR = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] oh,
  input  logic         en,
  output logic [N-1:0] therm,
  output logic         none,
  output logic         multi,
  output logic [N-1:0] therm_q,
  output logic         multi_q
);

  localparam int L = $clog2(N);

  logic [N-1:0] lvl [L+1];
  logic [N-1:0] outside;

  // Log-depth prefix OR: each level folds in bits 2^k positions away.
  always_comb begin
    lvl[0] = oh;
    for (int k = 0; k < L; k++) begin
      if (DIR == 0)
        lvl[k+1] = lvl[k] | (lvl[k] >> (1 << k));
      else
        lvl[k+1] = lvl[k] | (lvl[k] << (1 << k));
    end
  end

  assign therm = lvl[L];

  // OR of bits strictly beyond each position, in the fill direction.
  always_comb begin
    if (DIR == 0)
      outside = therm >> 1;
    else
      outside = therm << 1;
  end

  assign none  = ~|oh;
  assign multi = |(oh & outside);

  // Capture the combinational result when enabled; reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      therm_q <= '0;
      multi_q <= 1'b0;
    end else if (en) begin
      therm_q <= therm;
      multi_q <= multi;
    end
  end

endmodule

// File: tb/tb_onehot_to_therm.sv
// Randomized and directed bench for onehot_to_therm.
// Runs DIR=0 and DIR=1 instances side by side against a serial model.
module tb_onehot_to_therm;

  logic        clock;
  logic        reset;
  logic [31:0] oh;
  logic        en;

  logic [31:0] therm0, therm1, tq0, tq1;
  logic        none0, none1, multi0, multi1, mq0, mq1;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] e_tq0, e_tq1;
  logic        e_mq0, e_mq1;

  onehot_to_therm #(.N(32), .DIR(0)) u_d0 (
    .clock(clock), .reset(reset), .oh(oh), .en(en),
    .therm(therm0), .none(none0), .multi(multi0),
    .therm_q(tq0), .multi_q(mq0)
  );

  onehot_to_therm #(.N(32), .DIR(1)) u_d1 (
    .clock(clock), .reset(reset), .oh(oh), .en(en),
    .therm(therm1), .none(none1), .multi(multi1),
    .therm_q(tq1), .multi_q(mq1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_therm(input logic [31:0] v,
                                          input bit dir);
    logic [31:0] t;
    bit acc;
    t = '0;
    acc = 1'b0;
    if (!dir) begin
      for (int j = 31; j >= 0; j--) begin
        acc = acc | v[j];
        t[j] = acc;
      end
    end else begin
      for (int j = 0; j < 32; j++) begin
        acc = acc | v[j];
        t[j] = acc;
      end
    end
    return t;
  endfunction

  function automatic bit m_multi(input logic [31:0] v);
    return $countones(v) > 1;
  endfunction

  task automatic check_comb(input string tag);
    chk({tag, ".t0"}, {32'h0, therm0}, {32'h0, m_therm(oh, 1'b0)});
    chk({tag, ".t1"}, {32'h0, therm1}, {32'h0, m_therm(oh, 1'b1)});
    chk({tag, ".n0"}, {63'h0, none0}, {63'h0, oh == 32'h0});
    chk({tag, ".n1"}, {63'h0, none1}, {63'h0, oh == 32'h0});
    chk({tag, ".m0"}, {63'h0, multi0}, {63'h0, m_multi(oh)});
    chk({tag, ".m1"}, {63'h0, multi1}, {63'h0, m_multi(oh)});
  endtask

  task automatic check_q(input string tag);
    chk({tag, ".tq0"}, {32'h0, tq0}, {32'h0, e_tq0});
    chk({tag, ".tq1"}, {32'h0, tq1}, {32'h0, e_tq1});
    chk({tag, ".mq0"}, {63'h0, mq0}, {63'h0, e_mq0});
    chk({tag, ".mq1"}, {63'h0, mq1}, {63'h0, e_mq1});
  endtask

  function automatic logic [31:0] rnd_oh();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'h1 << $urandom_range(0, 31);
      1: v = (32'h1 << $urandom_range(0, 31)) |
             (32'h1 << $urandom_range(0, 31));
      2: v = $urandom;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    oh    = 32'h0000_0100;
    e_tq0 = '0; e_tq1 = '0; e_mq0 = 1'b0; e_mq1 = 1'b0;
    #1;
    check_q("rst_async");
    @(posedge clock); #1;
    check_q("rst_edge");
    check_comb("rst_comb");

    // Directed boundary values with literal expectations.
    oh = 32'h0000_0100; #1;
    chk("d100.t0", {32'h0, therm0}, {32'h0, 32'h0000_01FF});
    chk("d100.t1", {32'h0, therm1}, {32'h0, 32'hFFFF_FF00});
    chk("d100.nm", {62'h0, none0, multi0}, 64'h0);
    oh = 32'h8000_0000; #1;
    chk("dmsb.t0", {32'h0, therm0}, {32'h0, 32'hFFFF_FFFF});
    chk("dmsb.t1", {32'h0, therm1}, {32'h0, 32'h8000_0000});
    oh = 32'h0000_0001; #1;
    chk("dlsb.t0", {32'h0, therm0}, {32'h0, 32'h0000_0001});
    chk("dlsb.t1", {32'h0, therm1}, {32'h0, 32'hFFFF_FFFF});
    oh = 32'h0; #1;
    chk("dzero.t", {therm0, therm1}, 64'h0);
    chk("dzero.n", {62'h0, none0, none1}, 64'h3);
    chk("dzero.m", {62'h0, multi0, multi1}, 64'h0);
    oh = 32'h0000_0110; #1;
    chk("d110.t0", {32'h0, therm0}, {32'h0, 32'h0000_01FF});
    chk("d110.t1", {32'h0, therm1}, {32'h0, 32'hFFFF_FFF0});
    chk("d110.m", {62'h0, multi0, multi1}, 64'h3);

    // One-hot sweep from MSB down to LSB, then zero.
    for (int i = 31; i >= 0; i--) begin
      oh = 32'h1 << i; #1;
      check_comb("sweep");
    end
    oh = 32'h0; #1;
    check_comb("sweep0");

    // Leave reset mid-cycle, then capture and hold sequence.
    @(negedge clock);
    reset = 1'b0;
    oh = 32'h10; en = 1'b1;
    @(posedge clock); #1;
    chk("seq.cap", {32'h0, tq0}, {32'h0, 32'h1F});
    @(negedge clock);
    en = 1'b0; oh = 32'h1;
    @(posedge clock); #1;
    chk("seq.hold", {32'h0, tq0}, {32'h0, 32'h1F});
    e_tq0 = 32'h1F; e_tq1 = 32'hFFFF_FFF0;
    e_mq0 = 1'b0;  e_mq1 = 1'b0;
    check_q("seq");

    // Randomized traffic with random enable.
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      oh = rnd_oh();
      en = 1'($urandom_range(0, 1));
      #1;
      check_comb("rnd");
      if (en) begin
        e_tq0 = m_therm(oh, 1'b0);
        e_tq1 = m_therm(oh, 1'b1);
        e_mq0 = m_multi(oh);
        e_mq1 = m_multi(oh);
      end
      @(posedge clock); #1;
      check_q("rnd");
    end

    // Get a nonzero multi-hot capture, then reset mid-cycle.
    @(negedge clock);
    oh = 32'h0000_0110; en = 1'b1;
    @(posedge clock); #1;
    chk("pre.mq", {62'h0, mq0, mq1}, 64'h3);
    #2;
    reset = 1'b1;
    #1;
    e_tq0 = '0; e_tq1 = '0; e_mq0 = 1'b0; e_mq1 = 1'b0;
    check_q("mid_rst");
    check_comb("rst_comb2");
    @(posedge clock); #1;
    check_q("rst_en");
    @(negedge clock);
    reset = 1'b0; en = 1'b0;
    @(posedge clock); #1;
    check_q("post_rst_hold");
    @(negedge clock);
    en = 1'b1;
    @(posedge clock); #1;
    e_tq0 = 32'h0000_01FF; e_tq1 = 32'hFFFF_FFF0;
    e_mq0 = 1'b1; e_mq1 = 1'b1;
    check_q("first_cap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
